// File: rtl/t08_lsu.sv
// Multi-cycle load/store unit for the t08 CPU: one request at a time onto a
// word-aligned MMIO bus with byte enables, reporting busy/done/error.
module t08_lsu #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [2:0]        func3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic [31:0]       load_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_be,
  output logic              bus_read,
  output logic              bus_write,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ack
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FIN, S_FAULT} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [ADDR_W-1:0] bus_addr_reg;
  logic [31:0]       bus_wdata_reg;
  logic [3:0]        bus_be_reg;
  logic              dir_read_reg;
  logic [2:0]        func3_reg;
  logic [1:0]        offset_reg;
  logic [31:0]       load_data_reg;

  logic        func_ok, misalign, req_ok, accept, capture;
  logic [3:0]  sb_be, sh_be, st_be;
  logic [31:0] st_wdata;
  logic [7:0]  rbyte [4];
  logic [7:0]  lb_sel;
  logic [15:0] lh_sel;
  logic [31:0] ld_ext;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rbyte[gi] = bus_rdata[8*gi +: 8];
      assign sb_be[gi] = (addr[1:0] == 2'(gi));
      assign sh_be[gi] = (addr[1] == 1'(gi / 2));
    end
  endgenerate

  // Request legality: both lines high, bad width code or misalignment all fault.
  always_comb begin
    func_ok  = req_read ? (func3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (func3 <= 3'd2);
    misalign = ((func3[1:0] == 2'd1) && addr[0]) ||
               ((func3[1:0] == 2'd2) && (addr[1:0] != 2'b00));
    req_ok   = (req_read ^ req_write) && func_ok && !misalign;
  end

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = store_data;
    case (func3[1:0])
      2'd0: begin
        st_be    = sb_be;
        st_wdata = {4{store_data[7:0]}};
      end
      2'd1: begin
        st_be    = sh_be;
        st_wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    lb_sel = rbyte[offset_reg];
    lh_sel = offset_reg[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (func3_reg)
      3'd0:    ld_ext = {{24{lb_sel[7]}}, lb_sel};
      3'd1:    ld_ext = {{16{lh_sel[15]}}, lh_sel};
      3'd4:    ld_ext = {24'd0, lb_sel};
      3'd5:    ld_ext = {16'd0, lh_sel};
      default: ld_ext = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FIN/FAULT decode requests like IDLE so a held request is taken on the exit edge.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      S_WAIT: begin
        if (bus_ack) begin
          state_next = S_FIN;
          capture    = dir_read_reg;
        end else if (TO_EN && (cnt_reg == CNT_LAST)) begin
          state_next = S_FAULT;
        end
      end
      default: begin
        state_next = S_IDLE;
        if (req_read || req_write) begin
          accept     = 1'b1;
          state_next = req_ok ? S_WAIT : S_FAULT;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      cnt_reg       <= '0;
      bus_addr_reg  <= '0;
      bus_wdata_reg <= '0;
      bus_be_reg    <= '0;
      dir_read_reg  <= 1'b0;
      func3_reg     <= '0;
      offset_reg    <= '0;
      load_data_reg <= '0;
    end else begin
      cnt_reg <= (state_reg == S_WAIT) ? cnt_reg + CNT_W'(1) : '0;
      if (accept && req_ok) begin
        bus_addr_reg  <= {addr[ADDR_W-1:2], 2'b00};
        bus_be_reg    <= req_read ? 4'b1111 : st_be;
        bus_wdata_reg <= st_wdata;
        dir_read_reg  <= req_read;
        func3_reg     <= func3;
        offset_reg    <= addr[1:0];
      end
      if (capture) begin
        load_data_reg <= ld_ext;
      end
    end
  end

  assign load_data = load_data_reg;
  assign busy      = (state_reg != S_IDLE);
  assign done      = (state_reg == S_FIN);
  assign error     = (state_reg == S_FAULT);
  assign bus_addr  = bus_addr_reg;
  assign bus_wdata = bus_wdata_reg;
  assign bus_be    = bus_be_reg;
  assign bus_read  = (state_reg == S_WAIT) &&  dir_read_reg;
  assign bus_write = (state_reg == S_WAIT) && !dir_read_reg;

endmodule

// File: tb/tb_t08_lsu.sv
// Scoreboard bench for t08_lsu: stimulus pushes expected outcomes computed
// from the load/store rules; a negedge monitor pops and compares them.
module tb_t08_lsu;
  localparam int TO = 6;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        req_read = 1'b0, req_write = 1'b0;
  logic [2:0]  func3 = '0;
  logic [31:0] addr = '0, store_data = '0;
  logic [31:0] load_data, bus_addr, bus_wdata, bus_rdata = '0;
  logic        busy, done, error, bus_read, bus_write, bus_ack = 1'b0;
  logic [3:0]  bus_be;

  int checks = 0, failures = 0;
  int ack_delay = 0, wait_cnt = 0;
  logic [31:0] resp_rdata = '0;
  logic [31:0] model_ld = '0;
  bit abort_mode = 0;
  int txn_no = 0;

  typedef struct {
    bit err; logic [31:0] ld; logic [31:0] baddr; logic [3:0] be; logic [31:0] wd;
    bit rd; bit wr; int busy_c; int strobe_c;
  } exp_t;
  exp_t exp_q[$];

  t08_lsu #(.ADDR_W(32), .TIMEOUT(TO)) u_dut (
    .clk(clk), .nRst(nRst), .req_read(req_read), .req_write(req_write),
    .func3(func3), .addr(addr), .store_data(store_data), .load_data(load_data),
    .busy(busy), .done(done), .error(error), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_read(bus_read),
    .bus_write(bus_write), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: legality, lanes, extension and cycle counts from the rules directly.
  function automatic exp_t model(input bit rd, input bit wr, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] sd,
                                 input int dly, input logic [31:0] rdv,
                                 input logic [31:0] ld_prev);
    exp_t e;
    int sz = int'(f3) % 4;
    int off = int'(a % 4);
    bit ok = (rd != wr);
    logic [31:0] bytev, halfv;
    if (rd && !(f3 inside {0, 1, 2, 4, 5})) ok = 0;
    if (wr && f3 > 2) ok = 0;
    if (sz == 1 && (off % 2) != 0) ok = 0;
    if (sz == 2 && off != 0) ok = 0;
    e.rd = rd && ok; e.wr = wr && ok;
    e.baddr = a - 32'(off); e.ld = ld_prev; e.be = 4'hF; e.wd = 32'h0;
    if (wr && ok) begin
      if (sz == 0) begin e.be = 4'(1 << off); e.wd = (sd % 256) * 32'h0101_0101; end
      else if (sz == 1) begin e.be = (off >= 2) ? 4'hC : 4'h3; e.wd = (sd % 65536) * 32'h0001_0001; end
      else begin e.be = 4'hF; e.wd = sd; end
    end
    if (!ok) begin
      e.err = 1; e.busy_c = 1; e.strobe_c = 0;
    end else if (dly >= TO) begin
      e.err = 1; e.busy_c = TO + 1; e.strobe_c = TO;
    end else begin
      e.err = 0; e.busy_c = dly + 2; e.strobe_c = dly + 1;
      if (rd) begin
        bytev = (rdv >> (8 * off)) & 32'hFF;
        halfv = (rdv >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
          3'd0: e.ld = (bytev >= 128) ? bytev + 32'hFFFF_FF00 : bytev;
          3'd1: e.ld = (halfv >= 32768) ? halfv + 32'hFFFF_0000 : halfv;
          3'd4: e.ld = bytev;
          3'd5: e.ld = halfv;
          default: e.ld = rdv;
        endcase
      end
    end
    return e;
  endfunction

  // Bus device: acks after ack_delay cycles of strobe; rdata is junk otherwise.
  always @(negedge clk) begin
    if (bus_read || bus_write) begin
      bus_ack = (wait_cnt == ack_delay);
      bus_rdata = bus_ack ? resp_rdata : $urandom;
      wait_cnt++;
    end else begin
      bus_ack = 1'b0;
      wait_cnt = 0;
      bus_rdata = $urandom;
    end
  end

  int busy_cnt = 0, strobe_cnt = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!nRst) begin
      busy_cnt = 0; strobe_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (bus_read || bus_write) begin
        strobe_cnt++;
        if (!abort_mode) begin
          if (exp_q.size() == 0) begin
            check("bus_unexpected", 64'(bus_read | bus_write), 64'd0);
          end else begin
            e = exp_q[0];
            check("bus_ctl", {26'd0, bus_read, bus_write, bus_be, bus_addr},
                  {26'd0, e.rd, e.wr, e.be, e.baddr});
            if (e.wr) check("bus_wdata", 64'(bus_wdata), 64'(e.wd));
          end
        end
      end
      if (done || error) begin
        if (abort_mode || exp_q.size() == 0) begin
          check("unexpected_end", {62'd0, done, error}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          txn_no++;
          check("outcome", {62'd0, done, error}, {62'd0, !e.err, e.err});
          check("load_data", 64'(load_data), 64'(e.ld));
          check("busy_cycles", 64'(busy_cnt), 64'(e.busy_c));
          check("strobe_cycles", 64'(strobe_cnt), 64'(e.strobe_c));
          $display("txn %0d %s rd=%0d wr=%0d be=%h addr=%h ld=%h busy=%0d strobe=%0d",
                   txn_no, error ? "error" : "done", e.rd, e.wr, bus_be, bus_addr,
                   load_data, busy_cnt, strobe_cnt);
        end
        busy_cnt = 0; strobe_cnt = 0;
      end
    end
  end

  task automatic run_txn(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd,
                         input int dly, input logic [31:0] rdv);
    exp_t e;
    int n = 0;
    bit garbage = 0;
    @(negedge clk);
    e = model(rd, wr, f3, a, sd, dly, rdv, model_ld);
    model_ld = e.ld;
    exp_q.push_back(e);
    req_read = rd; req_write = wr; func3 = f3; addr = a; store_data = sd;
    ack_delay = dly; resp_rdata = rdv;
    @(negedge clk);
    req_read = 0; req_write = 0;
    // Requests raised mid-transfer must be ignored; drop them before FIN/FAULT exits.
    while (busy && n < 64) begin
      @(negedge clk);
      n++;
      if (garbage) begin
        req_read = 0; req_write = 0; garbage = 0;
      end else if ((bus_read || bus_write) && $urandom_range(0, 2) == 0) begin
        req_read = 1'($urandom); req_write = 1'($urandom);
        func3 = 3'($urandom); addr = $urandom; store_data = $urandom;
        garbage = 1;
      end
    end
    req_read = 0; req_write = 0;
    if (n >= 64) begin
      checks++; failures++;
      $display("FAIL busy_timeout actual=busy required=idle within 64 cycles");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] f3;
    logic [31:0] a;
    int kind;
    bit rd, wr;
    repeat (3) @(negedge clk);
    check("reset_outputs", {26'd0, busy, done, error, bus_read, bus_write, bus_be},
          64'd0);
    check("reset_bus", {bus_addr, bus_wdata}, 64'd0);
    check("reset_ld", 64'(load_data), 64'd0);
    nRst = 1'b1;

    run_txn(1, 0, 3'd2, 32'h0000_0010, 32'h0, 3, 32'hDEAD_BEEF);
    run_txn(1, 0, 3'd0, 32'h0000_0023, 32'h0, 1, 32'h80FF_7F01);
    run_txn(1, 0, 3'd4, 32'h0000_0023, 32'h0, 0, 32'h80FF_7F01);
    run_txn(1, 0, 3'd5, 32'h0000_0022, 32'h0, 2, 32'h80FF_7F01);
    run_txn(0, 1, 3'd1, 32'h0000_0006, 32'h1234_ABCD, 0, 32'h0);
    run_txn(1, 0, 3'd2, 32'h0000_0002, 32'h0, 0, 32'h1111_1111);
    run_txn(0, 1, 3'd1, 32'h0000_0001, 32'h5555_5555, 0, 32'h0);
    run_txn(1, 0, 3'd3, 32'h0000_0008, 32'h0, 0, 32'h2222_2222);
    run_txn(1, 1, 3'd2, 32'h0000_0008, 32'h0, 0, 32'h3333_3333);
    run_txn(1, 0, 3'd2, 32'h0000_0030, 32'h0, 255, 32'h4444_4444);
    run_txn(1, 0, 3'd1, 32'h0000_0032, 32'h0, TO - 1, 32'hC001_7FFF);
    run_txn(0, 1, 3'd0, 32'h0000_0041, 32'hAAAA_AA5A, TO, 32'h0);

    // Reset during WAIT abandons the transfer with no completion pulse.
    @(negedge clk);
    abort_mode = 1;
    req_read = 1; func3 = 3'd2; addr = 32'h40; ack_delay = 255;
    @(negedge clk);
    req_read = 0;
    repeat (2) @(negedge clk);
    #2 nRst = 1'b0;
    #1;
    check("rst_abort", {59'd0, busy, bus_read, bus_write, done, error}, 64'd0);
    check("rst_abort_ld", 64'(load_data), 64'd0);
    model_ld = '0;
    repeat (3) @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);
    abort_mode = 0;
    run_txn(0, 1, 3'd2, 32'h0000_0100, 32'hCAFE_F00D, 1, 32'h0);

    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 9);
      rd = (kind == 0) || (kind < 5);
      wr = (kind == 0) || (kind >= 5);
      if ($urandom_range(0, 9) < 7)
        f3 = rd && !wr ? 3'($urandom_range(0, 4) < 3 ? $urandom_range(0, 2) : $urandom_range(4, 5))
                       : 3'($urandom_range(0, 2));
      else
        f3 = 3'($urandom);
      a = $urandom;
      if ($urandom_range(0, 9) < 7) begin
        if (f3[1:0] == 2'd1) a[0] = 1'b0;
        if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
      end
      run_txn(rd, wr, f3, a, $urandom, $urandom_range(0, 9), $urandom);
    end

    repeat (4) @(negedge clk);
    check("queue_drain", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
